alu_arbiter: RTL

- Two-requester arbiter and sequencer for the shared 8-bit ALU (ops kADD, kSUB, kAND, kOR, kSLL, kSRL, kSLT, kSLTU, kTWCMP, kABS from the definitions package).
- Accepts one operation at a time from either requester, using round-robin grant.
- Drives the ALU from registered operands, captures Result/OvOutALU, and returns them to the owning requester with a valid/ready handshake.
- Sits between the decode/issue logic and the combinational ALU instance.

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a shared combinational ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP and is returned only to its owner.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 4,
  parameter int RR_INIT = 0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             Req0Valid,
  input  logic [OPW-1:0]   Req0Op,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  input  logic [WIDTH-1:0] Req0C,
  output logic             Req0Ready,
  output logic             Resp0Valid,
  input  logic             Resp0Ready,
  output logic [WIDTH-1:0] Resp0Result,
  output logic             Resp0Ov,
  input  logic             Req1Valid,
  input  logic [OPW-1:0]   Req1Op,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  input  logic [WIDTH-1:0] Req1C,
  output logic             Req1Ready,
  output logic             Resp1Valid,
  input  logic             Resp1Ready,
  output logic [WIDTH-1:0] Resp1Result,
  output logic             Resp1Ov,
  output logic [OPW-1:0]   ALUOp,
  output logic [WIDTH-1:0] ALUSrcA,
  output logic [WIDTH-1:0] ALUSrcB,
  output logic [WIDTH-1:0] ALUSrcC,
  input  logic [WIDTH-1:0] Result,
  input  logic             OvOutALU,
  output logic             Busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic RR_BIT = (RR_INIT != 0) ? 1'b1 : 1'b0;

  logic [1:0]       state_r;
  logic             prio_r;   // requester favoured when both ask
  logic             owner_r;
  logic [OPW-1:0]   op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] c_r;
  logic [WIDTH-1:0] res_r;
  logic             ov_r;

  logic grant_vld_s;
  logic grant_id_s;
  logic resp_vld_s;
  logic resp_done_s;

  // Combinational grant in IDLE; masked while reset is asserted.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if ((state_r == IDLE) && !reset) begin
      if (Req0Valid && Req1Valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = prio_r;
      end else if (Req0Valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (Req1Valid) begin
        grant_vld_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
      end
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Response side handshake decode for the current owner only.
  always_comb begin
    resp_vld_s  = 1'b0;
    resp_done_s = 1'b0;
    if ((state_r == RESP) && !reset) begin
      resp_vld_s  = 1'b1;
      resp_done_s = owner_r ? Resp1Ready : Resp0Ready;
    end else begin
      resp_vld_s  = 1'b0;
      resp_done_s = 1'b0;
    end
  end

  assign Req0Ready   = grant_vld_s && !grant_id_s;
  assign Req1Ready   = grant_vld_s &&  grant_id_s;
  assign Resp0Valid  = resp_vld_s && !owner_r;
  assign Resp1Valid  = resp_vld_s &&  owner_r;
  assign Resp0Result = owner_r ? {WIDTH{1'b0}} : res_r;
  assign Resp1Result = owner_r ? res_r : {WIDTH{1'b0}};
  assign Resp0Ov     = owner_r ? 1'b0 : ov_r;
  assign Resp1Ov     = owner_r ? ov_r : 1'b0;
  assign ALUOp       = op_r;
  assign ALUSrcA     = a_r;
  assign ALUSrcB     = b_r;
  assign ALUSrcC     = c_r;
  assign Busy        = (state_r != IDLE);

  // Sequencer state, operand drive registers and captured response.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= IDLE;
      prio_r  <= RR_BIT;
      owner_r <= 1'b0;
      op_r    <= {OPW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      c_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      ov_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            op_r    <= grant_id_s ? Req1Op : Req0Op;
            a_r     <= grant_id_s ? Req1A  : Req0A;
            b_r     <= grant_id_s ? Req1B  : Req0B;
            c_r     <= grant_id_s ? Req1C  : Req0C;
            owner_r <= grant_id_s;
            prio_r  <= ~grant_id_s;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          res_r   <= Result;
          ov_r    <= OvOutALU;
          state_r <= RESP;
        end
        RESP: begin
          if (resp_done_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
